// File: rtl/usb_pkg.sv
// Shared USB receive/transmit definitions: token PIDs, CRC5 constants and the
// token decoder state encoding.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_PING  = 4'b0100;

    localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;
    localparam logic [4:0] CRC5_PRESET   = 5'b11111;
    // x^5 + x^2 + 1 with the x^5 term implied by the shift
    localparam logic [4:0] CRC5_POLY     = 5'b00101;

    typedef enum logic [2:0] {
        StWaitIdle,
        StIdle,
        StPid,
        StTok1,
        StTok2,
        StEop,
        StDiscard
    } rx_state_e;

    function automatic logic is_token_pid(input logic [3:0] pid);
        return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SETUP) ||
               (pid == PID_SOF) || (pid == PID_PING);
    endfunction

endpackage

// File: rtl/usb_token_rx_if.sv
// Byte-level receive stream plus decoded token/error reporting for usb_token_rx.
interface usb_token_rx_if;

    logic        rx_active;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_error;
    logic [6:0]  dev_addr;

    logic        tok_valid;
    logic [3:0]  tok_pid;
    logic [6:0]  tok_addr;
    logic [3:0]  tok_endp;
    logic [10:0] tok_frame;
    logic        tok_match;
    logic        err_pid;
    logic        err_crc;
    logic        err_len;

    // master: the PHY/endpoint side; slave: the token decoder
    modport master (
        output rx_active, rx_valid, rx_data, rx_error, dev_addr,
        input  tok_valid, tok_pid, tok_addr, tok_endp, tok_frame, tok_match,
        input  err_pid, err_crc, err_len
    );

    modport slave (
        input  rx_active, rx_valid, rx_data, rx_error, dev_addr,
        output tok_valid, tok_pid, tok_addr, tok_endp, tok_frame, tok_match,
        output err_pid, err_crc, err_len
    );

endinterface

// File: rtl/usb_crc5_chk.sv
// Combinational 16-bit parallel CRC5 check over {r[4:0], t[10:0]}, bit 0 first.
module usb_crc5_chk
    import usb_pkg::*;
(
    input  logic [15:0] data,
    output logic [4:0]  residual,
    output logic        pass
);

    logic [4:0] crc;
    logic       fb;

    // Unrolled at elaboration: all 16 bit-steps collapse into one XOR network.
    always_comb begin
        crc = CRC5_PRESET;
        fb  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            fb  = data[i] ^ crc[4];
            crc = {crc[3:0], 1'b0} ^ ({5{fb}} & CRC5_POLY);
        end
        residual = crc;
        pass     = (crc == CRC5_RESIDUAL);
    end

endmodule

// File: rtl/usb_token_rx.sv
// USB token packet decoder: frames PID + 2 token bytes, checks PID and CRC5,
// reports one token or one error per token packet.
module usb_token_rx
    import usb_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    usb_token_rx_if.slave bus
);

    rx_state_e   state_q, state_d;
    logic [3:0]  pid_q, pid_d;
    logic [7:0]  byte1_q, byte1_d;
    logic [7:0]  byte2_q, byte2_d;

    logic        tok_valid_q, tok_valid_d;
    logic        err_pid_q, err_pid_d;
    logic        err_crc_q, err_crc_d;
    logic        err_len_q, err_len_d;
    logic [3:0]  tok_pid_q;
    logic [10:0] tok_frame_q;
    logic        tok_match_q, tok_match_d;
    logic        tok_load;

    logic [4:0]  crc_residual;
    logic        crc_pass;

    // byte2 carries r[4:0] above t[10:8], so {byte2, byte1} is exactly {r, t}
    usb_crc5_chk u_crc5_chk (
        .data     ({byte2_q, byte1_q}),
        .residual (crc_residual),
        .pass     (crc_pass)
    );

    assign tok_match_d = (pid_q == PID_SOF) || (byte1_q[6:0] == bus.dev_addr);

    always_comb begin
        state_d     = state_q;
        pid_d       = pid_q;
        byte1_d     = byte1_q;
        byte2_d     = byte2_q;
        tok_valid_d = 1'b0;
        err_pid_d   = 1'b0;
        err_crc_d   = 1'b0;
        err_len_d   = 1'b0;
        tok_load    = 1'b0;

        case (state_q)
            StWaitIdle: begin
                if (!bus.rx_active) state_d = StIdle;
            end
            StIdle: begin
                if (bus.rx_active) state_d = StPid;
            end
            StPid: begin
                if (!bus.rx_active) begin
                    state_d = StIdle;
                end else if (bus.rx_error) begin
                    state_d = StDiscard;
                end else if (bus.rx_valid) begin
                    pid_d = bus.rx_data[3:0];
                    if (bus.rx_data[7:4] != ~bus.rx_data[3:0]) begin
                        err_pid_d = 1'b1;
                        state_d   = StDiscard;
                    end else if (is_token_pid(bus.rx_data[3:0])) begin
                        state_d = StTok1;
                    end else begin
                        state_d = StDiscard;
                    end
                end
            end
            StTok1, StTok2: begin
                if (!bus.rx_active) begin
                    err_len_d = 1'b1;
                    state_d   = StIdle;
                end else if (bus.rx_error) begin
                    err_len_d = 1'b1;
                    state_d   = StDiscard;
                end else if (bus.rx_valid) begin
                    if (state_q == StTok1) begin
                        byte1_d = bus.rx_data;
                        state_d = StTok2;
                    end else begin
                        byte2_d = bus.rx_data;
                        state_d = StEop;
                    end
                end
            end
            StEop: begin
                // End of packet wins over a byte presented in the same cycle
                if (!bus.rx_active) begin
                    tok_valid_d = crc_pass;
                    tok_load    = crc_pass;
                    err_crc_d   = (crc_residual != CRC5_RESIDUAL);
                    state_d     = StIdle;
                end else if (bus.rx_error || bus.rx_valid) begin
                    err_len_d = 1'b1;
                    state_d   = StDiscard;
                end
            end
            StDiscard: begin
                if (!bus.rx_active) state_d = StIdle;
            end
            default: state_d = StWaitIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StWaitIdle;
            pid_q       <= '0;
            byte1_q     <= '0;
            byte2_q     <= '0;
            tok_valid_q <= 1'b0;
            err_pid_q   <= 1'b0;
            err_crc_q   <= 1'b0;
            err_len_q   <= 1'b0;
            tok_pid_q   <= '0;
            tok_frame_q <= '0;
            tok_match_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pid_q       <= pid_d;
            byte1_q     <= byte1_d;
            byte2_q     <= byte2_d;
            tok_valid_q <= tok_valid_d;
            err_pid_q   <= err_pid_d;
            err_crc_q   <= err_crc_d;
            err_len_q   <= err_len_d;
            if (tok_load) begin
                tok_pid_q   <= pid_q;
                tok_frame_q <= {byte2_q[2:0], byte1_q};
                tok_match_q <= tok_match_d;
            end
        end
    end

    assign bus.tok_valid = tok_valid_q;
    assign bus.tok_pid   = tok_pid_q;
    assign bus.tok_frame = tok_frame_q;
    assign bus.tok_addr  = tok_frame_q[6:0];
    assign bus.tok_endp  = tok_frame_q[10:7];
    assign bus.tok_match = tok_match_q;
    assign bus.err_pid   = err_pid_q;
    assign bus.err_crc   = err_crc_q;
    assign bus.err_len   = err_len_q;

endmodule

// File: doc/usb_token_rx.md
# usb_token_rx

Receive-side USB token decoder. It sits between the byte-level receive interface (UTMI-style `rx_active`/`rx_valid`/`rx_data`) and the device endpoint logic. It frames 3-byte token packets (OUT, IN, SETUP, SOF, PING), validates the PID check nibble, checks the 5-bit CRC over the 11-bit token field, and reports one decoded token or one error per packet. Non-token packets (DATA, handshake, and others) are ignored silently so other decoders can take them.

## Interface
- `dev_addr` input rather than a parameter. There are no parameters.
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, synchronous, active-low. One clock; every register resets on the `clk` edge where `rst_n`=0.
- `rx_active` in 1: high for the duration of a received packet, SYNC through EOP.
- `rx_valid` in 1: `rx_data` holds a byte this cycle. Only qualified while `rx_active`=1.
- `rx_data` in 8: received byte, first byte is the PID.
- `rx_error` in 1: PHY error (bit-stuff or similar). Qualified while `rx_active`=1.
- `dev_addr` in 7: this device's address.
- `tok_valid` out 1: one-cycle pulse, good token decoded.
- `tok_pid` out 4: PID[3:0] of the token.
- `tok_addr` out 7: address field, t[6:0]. Zero-extended garbage for SOF.
- `tok_endp` out 4: endpoint field, t[10:7].
- `tok_frame` out 11: full token field t[10:0]. This is the frame number for SOF.
- `tok_match` out 1: qualified by `tok_valid`. High if the PID is SOF or `tok_addr`==`dev_addr`.
- `err_pid` out 1: one-cycle pulse, PID[7:4] != ~PID[3:0].
- `err_crc` out 1: one-cycle pulse, token CRC5 residual mismatch.
- `err_len` out 1: one-cycle pulse, token packet length is not exactly 3 bytes, or `rx_error` was asserted during a token.

## Operation
- **Field mapping.** Byte0 is the PID. t[7:0]=byte1. t[10:8]=byte2[2:0]. Received CRC field r[4:0]=byte2[7:3].
- **CRC check.** Feed t[0..10], then r[0..4], LSB-first into CRC5 x^5+x^2+1 with preset 11111. The packet passes iff the final register is 01100 (the USB residual). A parallel 16-bit implementation is required; a serial one is not acceptable.
- **Token PIDs.** PID[3:0] ∈ {0001 OUT, 1001 IN, 1101 SETUP, 0101 SOF, 0100 PING}.
- **FSM states:**
  - WAIT_IDLE: reset state. Go to IDLE when `rx_active`=0. This prevents parsing a packet already in flight at reset release.
  - IDLE: `rx_active`=1 → PID.
  - PID: on a valid byte, latch the PID.
    - Check nibble bad → pulse `err_pid`, go to DISCARD.
    - Check nibble good but PID is not a token → DISCARD, with no error.
    - Token PID → TOK1.
  - TOK1: valid byte → latch byte1 → TOK2.
  - TOK2: valid byte → latch byte2 → EOP.
  - EOP: wait for `rx_active`=0.
  - DISCARD: wait for `rx_active`=0 → IDLE. No outputs.
- **Any token state (TOK1/TOK2/EOP):**
  - `rx_active` falls in TOK1 or TOK2 (short packet) → `err_len`, IDLE.
  - A valid byte arrives in EOP (long packet) → `err_len`, DISCARD.
  - `rx_error`=1 → `err_len`, DISCARD.
- **End of packet in EOP.** When `rx_active`=0 is sampled, evaluate the CRC.
  - Pass → `tok_valid`.
  - Fail → `err_crc`.
  - Then go to IDLE.
- **Exclusivity.** At most one of `tok_valid`/`err_*` is asserted per packet.
- **Simultaneous inputs.** `rx_valid`=1 together with `rx_active`=0 means the byte is ignored and end-of-packet is processed.
- **Output hold.** `tok_pid`/`tok_addr`/`tok_endp`/`tok_frame` are registered and hold their last good token between pulses. `tok_match` is meaningful only with `tok_valid`.

## Timing
- **Reset values.** All pulses are 0. `tok_pid`/`tok_addr`/`tok_endp`/`tok_frame` are 0. State is WAIT_IDLE.
- **Token latency.** `tok_valid`/`err_crc` are asserted on the cycle after the first edge where `rx_active`=0 is sampled in EOP.
- **PID error latency.** `err_pid` is asserted the cycle after the PID byte is accepted.
- **Length error latency.** `err_len` is asserted the cycle after the offending condition is sampled.
- **Back-to-back packets.** The decoder is back in IDLE on the cycle `tok_valid` is high, so a new packet may raise `rx_active` that cycle with no loss.
- **Byte gaps.** Arbitrary idle gaps between `rx_valid` bytes are allowed.
- **Reset mid-packet.** Outputs clear the next edge and no pulse is emitted. The decoder then waits in WAIT_IDLE for `rx_active`=0.

## Structure
- **Shared package `usb_pkg`:**
  - PID constants: `PID_OUT`, `PID_IN`, `PID_SETUP`, `PID_SOF`, `PID_PING`.
  - `CRC5_RESIDUAL`=5'b01100.
  - `CRC5_PRESET`=5'b11111.
  - The FSM state enum.
- **Sub-module `usb_crc5_chk`.** A combinational 16-bit parallel CRC5 with input {r,t}, giving a residual output and pass flag. It is reused by the transmit token builder.

## Test plan
- **Good SETUP.** 2D 00 10, `dev_addr`=0 → `tok_valid`=1, pid=1101, addr=0, endp=0, `tok_match`=1, with the pulse 1 cycle after `rx_active` falls.
- **CRC corruption.** 2D 00 18 (one CRC bit flipped) → `err_crc`=1 only. The `tok_*` fields keep their previous values.
- **PID check nibble.** PID 2C → `err_pid` the cycle after the PID byte. The following bytes are ignored and there is no further pulse.
- **Length errors.**
  - 2D 00 then `rx_active` falls → `err_len`.
  - 2D 00 10 55 → `err_len` on the 4th byte, and no `tok_valid`.
- **Non-token packets.**
  - C3 xx xx (DATA0) → no outputs.
  - `rx_error` mid-token → `err_len`.
  - Address match: a token with addr≠`dev_addr` gives `tok_match`=0; SOF gives `tok_match`=1 for any address.
- **Reset and back-to-back.** Assert `rst_n`=0 during TOK2 and release with `rx_active` still high → no pulse until `rx_active` drops. The next good packet then decodes. Two packets sent back-to-back with zero gap → two `tok_valid` pulses.
